// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI request arbiter.
// Used by spi_req_arbiter and rr_arbiter.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_GAP   = 3'd4
    } arb_state_e;

    localparam int MAX_REQ = 8;

    // Round-robin pointer advance: one past the granted index, wrapping at n.
    function automatic int ptr_next(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/spi_req_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or above the pointer,
// wrapping modulo N. Produces one-hot grant, grant index and an any-valid flag.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_oh_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_o
);

    always_comb begin
        int k;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        k         = 0;
        for (int off = 0; off < N; off++) begin
            k = int'(ptr_i) + off;
            if (k >= N) k = k - N;
            if (!any_o && valid_i[k]) begin
                any_o       = 1'b1;
                gnt_idx_o   = IW'(k);
                gnt_oh_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one SPI master engine between NUM_REQ requesters: round-robin accept, start,
// wait for done, respond, inter-frame gap. Optional WAIT watchdog via SPI_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | offer ready to the round-robin winner, accept on valid
// START | one-cycle engine start, select the granted device
// WAIT  | select held, waiting for engine done (or watchdog expiry)
// RESP  | one-cycle response pulse to the granted requester
// GAP   | GAP_CYC cycles with all selects low
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 16,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic                      o_spi_start,
    output logic [DATA_W-1:0]         o_spi_tx,
    input  logic                      i_spi_done,
    input  logic [DATA_W-1:0]         i_spi_rx,
    output logic [NUM_REQ-1:0]        o_cs_sel,
    output logic                      o_busy,
    output logic                      o_timeout
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    if (NUM_REQ < 1 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("spi_req_arbiter: NUM_REQ out of range");
    end

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       gidx_q;
    logic [DATA_W-1:0]   tx_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [GW-1:0]       gap_cnt_q;

    logic [NUM_REQ-1:0]  gnt_oh;
    logic [IW-1:0]       gnt_idx;
    logic                any_valid;
    logic [NUM_REQ-1:0]  sel_oh;
    logic                accept;
    logic                expire;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .valid_i   (i_req_valid),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .any_o     (any_valid)
    );

    assign accept = (state_q == ST_IDLE) && any_valid;

    always_comb begin
        sel_oh         = '0;
        sel_oh[gidx_q] = 1'b1;
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt_q;

    // Done in the expiry cycle takes priority over the watchdog.
    assign expire = (state_q == ST_WAIT) && !i_spi_done && (tmo_cnt_q == TW'(TIMEOUT_CYC));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
        end else begin
            tmo_cnt_q <= '0;
        end
    end
`else
    logic unused_timeout_cfg;
    assign expire             = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (any_valid) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (i_spi_done || expire) state_d = ST_RESP;
            ST_RESP:  state_d = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:   if (gap_cnt_q == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr_q      <= '0;
            gidx_q     <= '0;
            tx_q       <= '0;
            rsp_data_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            if (accept) begin
                gidx_q <= gnt_idx;
                tx_q   <= i_req_data[int'(gnt_idx)*DATA_W +: DATA_W];
                ptr_q  <= IW'(ptr_next(int'(gnt_idx), NUM_REQ));
            end
            if (state_q == ST_WAIT && i_spi_done) begin
                rsp_data_q <= i_spi_rx;
            end else if (expire) begin
                rsp_data_q <= '1;
            end
            // Loaded in RESP so GAP lasts exactly GAP_CYC cycles.
            if (state_q == ST_RESP) begin
                gap_cnt_q <= GW'(GAP_CYC - 1);
            end else if (state_q == ST_GAP && gap_cnt_q != '0) begin
                gap_cnt_q <= gap_cnt_q - GW'(1);
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        o_rsp_valid = '0;
        o_cs_sel    = '0;
        o_spi_start = 1'b0;
        o_busy      = (state_q != ST_IDLE);
        o_timeout   = expire;
        unique case (state_q)
            ST_IDLE:  o_req_ready = gnt_oh;
            ST_START: begin
                o_spi_start = 1'b1;
                o_cs_sel    = sel_oh;
            end
            ST_WAIT:  o_cs_sel = sel_oh;
            ST_RESP:  o_rsp_valid = sel_oh;
            ST_GAP:   ;
            default:  ;
        endcase
    end

    assign o_spi_tx   = tx_q;
    assign o_rsp_data = rsp_data_q;

endmodule
